// File: rtl/piano_tone_gen.sv
// Key-to-tone engine: lowest pressed key wins, octave shift, pitch changes only at toggle edges, timed release tail.
// Latency: 2 cycles from key press to PLAY, first buzzer rise hp cycles later; no backpressure (free-running outputs).
module piano_tone_gen #(
    parameter int NUM_KEYS = 8,
    parameter int DIV_W    = 18,
    parameter int OCT_W    = 2,
    parameter logic [NUM_KEYS*DIV_W-1:0] HALF_TABLE = {
        18'd95557,  18'd101239, 18'd113636, 18'd127551,
        18'd143172, 18'd151685, 18'd170265, 18'd191110},
    parameter int RELEASE_CYC = 5000000,
    localparam int IDX_W = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_input,
    input  logic                key_on,
    input  logic [OCT_W-1:0]    octave,
    output logic                buzzer_output,
    output logic [NUM_KEYS-1:0] led_output,
    output logic [IDX_W-1:0]    note_idx,
    output logic                note_active
);
    localparam int REL_W = $clog2(RELEASE_CYC) + 1;

    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

    state_t              state_q, state_d;
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic                key_on_q, key_on_d;
    logic [OCT_W-1:0]    octave_q, octave_d;
    logic [DIV_W-1:0]    counter_q, counter_d;
    logic [REL_W-1:0]    rel_q, rel_d;
    logic                buzzer_q, buzzer_d;
    logic [IDX_W-1:0]    note_idx_q, note_idx_d;

    logic             pressed;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] eff_idx;
    logic [DIV_W-1:0] hp_raw;
    logic [DIV_W-1:0] hp;

    always_comb begin
        pressed = key_on_q & (|key_q);
        sel     = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_q[i]) sel = IDX_W'(i);
        end
        // While released, the held note keeps supplying the half-period.
        eff_idx = pressed ? sel : note_idx_q;
        hp_raw  = HALF_TABLE[eff_idx*DIV_W +: DIV_W] >> octave_q;
        hp      = (hp_raw == '0) ? DIV_W'(1) : hp_raw;
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_input;
        key_on_d   = key_on;
        octave_d   = octave;
        counter_d  = counter_q;
        rel_d      = rel_q;
        buzzer_d   = buzzer_q;
        note_idx_d = note_idx_q;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d    = PLAY;
                    counter_d  = hp - DIV_W'(1);
                    buzzer_d   = 1'b0;
                    note_idx_d = sel;
                end
            end
            default: begin
                if (state_q == RELEASE && !pressed && rel_q == '0) begin
                    state_d   = IDLE;
                    buzzer_d  = 1'b0;
                    counter_d = '0;
                end else begin
                    if (counter_q == '0) begin
                        buzzer_d   = ~buzzer_q;
                        counter_d  = hp - DIV_W'(1);
                        note_idx_d = eff_idx;
                    end else begin
                        counter_d = counter_q - DIV_W'(1);
                    end
                    if (state_q == PLAY) begin
                        if (!pressed) begin
                            state_d = RELEASE;
                            rel_d   = REL_W'(RELEASE_CYC - 1);
                        end
                    end else if (pressed) begin
                        state_d = PLAY;
                    end else begin
                        rel_d = rel_q - REL_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            key_on_q   <= 1'b0;
            octave_q   <= '0;
            counter_q  <= '0;
            rel_q      <= '0;
            buzzer_q   <= 1'b0;
            note_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            key_on_q   <= key_on_d;
            octave_q   <= octave_d;
            counter_q  <= counter_d;
            rel_q      <= rel_d;
            buzzer_q   <= buzzer_d;
            note_idx_q <= note_idx_d;
        end
    end

    assign buzzer_output = buzzer_q;
    assign note_active   = (state_q != IDLE);
    assign note_idx      = note_idx_q;
    assign led_output    = note_active ? (NUM_KEYS'(1) << note_idx_q) : '0;
endmodule

// File: tb/tb_piano_tone_gen.sv
// Scoreboard bench for piano_tone_gen: a half-period/event model predicts every cycle's outputs.
module tb_piano_tone_gen;
    localparam int NK  = 8;
    localparam int REL = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] key_input = '0;
    logic       key_on = 1'b0;
    logic [1:0] octave = '0;
    logic       buzzer_output;
    logic [7:0] led_output;
    logic [2:0] note_idx;
    logic       note_active;

    piano_tone_gen #(
        .NUM_KEYS(NK), .DIV_W(8), .OCT_W(2),
        .HALF_TABLE({8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10}),
        .RELEASE_CYC(REL)
    ) dut (
        .clk(clk), .rst(rst), .key_input(key_input), .key_on(key_on),
        .octave(octave), .buzzer_output(buzzer_output), .led_output(led_output),
        .note_idx(note_idx), .note_active(note_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       buz;
        logic [7:0] led;
        logic [2:0] idx;
        logic       act;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 0;

    // Behavioural model: state described as "sounding note, level, how far into
    // the current half-period, how many release cycles remain".
    int tbl[NK] = '{10, 9, 8, 7, 6, 5, 4, 3};
    int m_key = 0, m_on = 0, m_oct = 0;
    bit active = 0, releasing = 0, level = 0;
    int rel_left = 0, elapsed = 0, cur_hp = 1, cur_idx = 0;

    task automatic model_edge();
        bit press;
        int sel, eff, hp;
        if (!rst) begin
            active = 0; releasing = 0; level = 0; rel_left = 0;
            elapsed = 0; cur_hp = 1; cur_idx = 0;
            m_key = 0; m_on = 0; m_oct = 0;
            return;
        end
        press = (m_on != 0) && (m_key != 0);
        sel = 0;
        for (int k = NK - 1; k >= 0; k--) if (m_key[k]) sel = k;
        eff = press ? sel : cur_idx;
        hp = tbl[eff] >> m_oct;
        if (hp == 0) hp = 1;
        if (!active) begin
            if (press) begin
                active = 1; releasing = 0; cur_idx = sel;
                cur_hp = hp; elapsed = 0; level = 0;
            end
        end else if (releasing && !press && rel_left == 0) begin
            active = 0; releasing = 0; level = 0; elapsed = 0;
        end else begin
            if (elapsed == cur_hp - 1) begin
                level = ~level; cur_idx = eff; cur_hp = hp; elapsed = 0;
            end else begin
                elapsed++;
            end
            if (releasing) begin
                if (press) releasing = 0;
                else rel_left--;
            end else if (!press) begin
                releasing = 1; rel_left = REL - 1;
            end
        end
        m_key = int'(key_input); m_on = int'(key_on); m_oct = int'(octave);
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.buz = level;
        e.act = active;
        e.idx = 3'(cur_idx);
        e.led = active ? (8'd1 << cur_idx) : 8'd0;
        return e;
    endfunction

    typedef struct {
        logic [7:0] key;
        logic       on;
        logic [1:0] oct;
        logic       rst_n;
        int         len;
    } seg_t;

    seg_t segs[$];

    task automatic run_seg(input seg_t s);
        for (int c = 0; c < s.len; c++) begin
            @(negedge clk);
            key_input = s.key; key_on = s.on; octave = s.oct; rst = s.rst_n;
            model_edge();
            exp_q.push_back(model_out());
        end
    endtask

    // Monitor: outputs are presented every cycle, checked just after each edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {buzzer_output, led_output, note_idx, note_active};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got buz=%b led=%h idx=%0d act=%b want buz=%b led=%h idx=%0d act=%b",
                             $time, a.buz, a.led, a.idx, a.act, e.buz, e.led, e.idx, e.act);
                end
            end
        end
    end

    initial begin
        seg_t s;
        segs.push_back('{8'hFF, 1'b1, 2'd0, 1'b0, 3});   // reset with keys held
        segs.push_back('{8'h01, 1'b1, 2'd0, 1'b1, 60});  // key0, period 20
        segs.push_back('{8'h06, 1'b1, 2'd0, 1'b1, 40});  // key1 wins
        segs.push_back('{8'h06, 1'b1, 2'd1, 1'b1, 30});  // octave up
        segs.push_back('{8'h80, 1'b1, 2'd3, 1'b1, 16});  // clamp hp to 1
        segs.push_back('{8'h01, 1'b1, 2'd0, 1'b1, 15});
        segs.push_back('{8'h04, 1'b1, 2'd0, 1'b1, 30});  // switch mid half-period
        segs.push_back('{8'h00, 1'b1, 2'd0, 1'b1, 10});
        segs.push_back('{8'h08, 1'b1, 2'd0, 1'b1, 30});  // re-press during release
        segs.push_back('{8'h00, 1'b1, 2'd0, 1'b1, 40});  // full release tail
        segs.push_back('{8'h02, 1'b1, 2'd0, 1'b1, 20});
        segs.push_back('{8'h0F, 1'b0, 2'd0, 1'b1, 40});  // key_on low acts as release
        segs.push_back('{8'h01, 1'b1, 2'd0, 1'b1, 25});
        segs.push_back('{8'h01, 1'b1, 2'd0, 1'b0, 2});   // reset mid-note
        segs.push_back('{8'h00, 1'b1, 2'd0, 1'b1, 5});
        for (int r = 0; r < 150; r++) begin
            s.key   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            s.on    = ($urandom_range(0, 5) != 0);
            s.oct   = 2'($urandom_range(0, 3));
            s.rst_n = ($urandom_range(0, 30) != 0);
            s.len   = s.rst_n ? int'($urandom_range(1, 45)) : 2;
            segs.push_back(s);
        end
        foreach (segs[i]) run_seg(segs[i]);
        stim_done = 1;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain leftover=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
